// File: rtl/instr_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit_if
// Bundles the instruction-memory read port, the decode-side valid/ready
// instruction handshake and the branch redirect input of the fetch unit.
//
// master : fetch unit side (drives imem_req/imem_addr and the instruction
//          outputs; receives imem_rdata, instr_ready, redirect, redirect_pc)
// slave  : memory + decode side (the mirror image)
//
// Signals
//   imem_req     read request this cycle
//   imem_addr    word-aligned byte address of the read
//   imem_rdata   read data, valid one cycle after an imem_req cycle
//   instr        head instruction (NOP word when nothing buffered)
//   instr_pc     byte address of instr (0 when nothing buffered)
//   instr_valid  instr/instr_pc carry a real instruction
//   instr_ready  decode accepts the head this cycle
//   redirect     taken branch / PC write
//   redirect_pc  new fetch address (low 2 bits ignored)
// -----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect,
    output redirect_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
// Fetch/issue stage of the Filter-GPU core. Keeps the PC, issues reads to
// instruction memory and buffers returned words in a DEPTH-entry prefetch
// FIFO whose head is offered to decode over a valid/ready handshake. A taken
// branch (redirect) flushes the buffer, drops the in-flight response and
// restarts fetching at the new address.
//
// Ports
//   clk    clock, all state on the rising edge
//   rst_n  asynchronous reset, active low
//   bus    instr_fetch_unit_if.master (imem read port, instruction handshake,
//          redirect)
//
// Pipeline
//   p0 : request cycle (imem_req, imem_addr = pc)
//   p1 : response cycle (imem_rdata valid, pushed into the FIFO)
//   head of FIFO is visible on instr the cycle after the push
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int unsigned        ADDR_W   = 32,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter logic [31:0]        NOP_WORD = 32'hE1A00000
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] START_PC = RESET_PC & ~ADDR_W'(3);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // control state
  logic [ADDR_W-1:0] pc;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              vld_p1;     // a request was issued last cycle

  // data state (never reset; qualified by count / vld_p1)
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];

  logic              head_vld;
  logic              pop;
  logic              push;
  logic              squash;
  logic              credit;
  logic              req_p0;
  logic [CNT_W:0]    occ_post;

  assign head_vld = (count != '0);
  assign pop      = head_vld & bus.instr_ready;

  // A redirect kills the response arriving in the same cycle: it belongs
  // to the old instruction stream.
  assign squash   = bus.redirect & vld_p1;
  assign push     = vld_p1 & ~squash;

  // Slots already promised: what stays after this cycle's pop plus the
  // response landing now. A new request is allowed only if a slot is left,
  // so a push can never hit a full FIFO.
  assign occ_post = {1'b0, count} + (CNT_W+1)'(vld_p1) - (CNT_W+1)'(pop);
  assign credit   = (occ_post < (CNT_W+1)'(DEPTH));

  always_comb begin
    state_nxt = state;
    req_p0    = 1'b0;
    case (state)
      S_START: state_nxt = S_FETCH;
      S_FETCH: begin
        if (credit) begin
          req_p0 = 1'b1;
        end else begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (credit) begin
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_START;
    endcase
    // Redirect overrides everything: no request this cycle, restart next.
    if (bus.redirect) begin
      req_p0    = 1'b0;
      state_nxt = S_FETCH;
    end
  end

  // ---- p0 -> p1 boundary: request issue, PC advance, FIFO bookkeeping ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_START;
      pc     <= START_PC;
      vld_p1 <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= req_p0;

      if (bus.redirect) begin
        pc <= bus.redirect_pc & ~ADDR_W'(3);
      end else if (req_p0) begin
        pc <= pc + ADDR_W'(4);
      end

      if (bus.redirect) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push && !pop) begin
          count <= count + CNT_W'(1);
        end else if (pop && !push) begin
          count <= count - CNT_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
      end
    end
  end

  // ---- p1 -> FIFO boundary: capture response word and its address ----
  always_ff @(posedge clk) begin
    addr_p1 <= pc;
    if (push) begin
      fifo_data[wr_ptr] <= bus.imem_rdata;
      fifo_pc[wr_ptr]   <= addr_p1;
    end
  end

  assign bus.imem_req    = req_p0;
  assign bus.imem_addr   = pc;
  assign bus.instr_valid = head_vld;
  assign bus.instr       = head_vld ? fifo_data[rd_ptr] : NOP_WORD;
  assign bus.instr_pc    = head_vld ? fifo_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam logic [31:0] NOP    = 32'hE1A00000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0),
    .NOP_WORD (NOP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Memory returns a word derived from its address so every word is traceable.
  function automatic logic [31:0] tag(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Instruction memory: data valid exactly one cycle after a request, garbage otherwise.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_rdata <= tag(bus.imem_addr);
    else              bus.imem_rdata <= $urandom();
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Leaves the bench at posedge+1 of cycle 1 (the idle cycle after release).
  task automatic do_reset(input logic rdy);
    bus.instr_ready = rdy;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    sample();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b expected 0", bus.imem_req); end
    n_cmp++; if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h expected 00000000", bus.imem_addr); end
    n_cmp++; if (bus.instr !== NOP) begin n_bad++; $display("FAIL reset_instr: got %h expected %h", bus.instr, NOP); end
    n_cmp++; if (bus.instr_pc !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h expected 00000000", bus.instr_pc); end
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", bus.instr_valid); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    sample();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL start_idle_req: got %b expected 0", bus.imem_req); end
  endtask

  task automatic test_startup();
    do_reset(1'b1);
    next_cycle();
    for (int c = 2; c <= 8; c++) begin
      sample();
      n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'((c - 2) * 4)) begin
        n_bad++; $display("FAIL startup_req c%0d: got req=%b addr=%h expected req=1 addr=%h", c, bus.imem_req, bus.imem_addr, 32'((c - 2) * 4));
      end
      n_cmp++; if (bus.instr_valid !== (c >= 4)) begin
        n_bad++; $display("FAIL startup_valid c%0d: got %b expected %b", c, bus.instr_valid, (c >= 4));
      end
      if (c >= 4) begin
        n_cmp++; if (bus.instr_pc !== 32'((c - 4) * 4) || bus.instr !== tag(32'((c - 4) * 4))) begin
          n_bad++; $display("FAIL startup_head c%0d: got pc=%h instr=%h expected pc=%h", c, bus.instr_pc, bus.instr, 32'((c - 4) * 4));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_stall();
    int nreq;
    int npop;
    logic [31:0] first_after;
    logic        seen_after;
    nreq = 0; npop = 0; seen_after = 1'b0; first_after = '0;
    do_reset(1'b0);
    for (int c = 1; c <= 12; c++) begin
      sample();
      if (bus.imem_req) begin
        n_cmp++; if (bus.imem_addr !== 32'(nreq * 4)) begin
          n_bad++; $display("FAIL stall_addr: got %h expected %h", bus.imem_addr, 32'(nreq * 4));
        end
        nreq++;
      end
      if (c >= 4) begin
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0 || bus.instr !== tag(32'h0)) begin
          n_bad++; $display("FAIL stall_hold c%0d: got v=%b pc=%h instr=%h expected v=1 pc=00000000", c, bus.instr_valid, bus.instr_pc, bus.instr);
        end
      end
      if (c == 12) begin
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req_off: got %b expected 0", bus.imem_req); end
      end
      next_cycle();
    end
    n_cmp++; if (nreq != DEPTH) begin n_bad++; $display("FAIL stall_nreq: got %0d expected %0d", nreq, DEPTH); end
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      sample();
      if (bus.instr_valid && npop < 4) begin
        n_cmp++; if (bus.instr_pc !== 32'(npop * 4)) begin
          n_bad++; $display("FAIL stall_drain: got %h expected %h", bus.instr_pc, 32'(npop * 4));
        end
        npop++;
      end
      if (bus.imem_req && !seen_after) begin
        seen_after = 1'b1;
        first_after = bus.imem_addr;
      end
      next_cycle();
    end
    n_cmp++; if (npop != 4) begin n_bad++; $display("FAIL stall_npop: got %0d expected 4", npop); end
    n_cmp++; if (!seen_after || first_after !== 32'h10) begin
      n_bad++; $display("FAIL stall_resume: got seen=%b addr=%h expected addr=00000010", seen_after, first_after);
    end
  endtask

  task automatic test_redirect();
    do_reset(1'b0);
    repeat (5) next_cycle();                    // now at cycle 6: 3 buffered, 0xC in flight
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h103;
    sample();
    n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_noreq: got %b expected 0", bus.imem_req); end
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h0) begin
      n_bad++; $display("FAIL redir_pre: got v=%b pc=%h expected v=1 pc=00000000", bus.instr_valid, bus.instr_pc);
    end
    next_cycle();
    bus.redirect = 1'b0;
    sample();
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_flush: got %b expected 0", bus.instr_valid); end
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin
      n_bad++; $display("FAIL redir_restart: got req=%b addr=%h expected req=1 addr=00000100", bus.imem_req, bus.imem_addr);
    end
    next_cycle();
    sample();
    n_cmp++; if (bus.instr_valid !== 1'b0) begin n_bad++; $display("FAIL redir_n2: got %b expected 0", bus.instr_valid); end
    next_cycle();
    sample();
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 || bus.instr !== tag(32'h100)) begin
      n_bad++; $display("FAIL redir_first: got v=%b pc=%h instr=%h expected pc=00000100 instr=%h", bus.instr_valid, bus.instr_pc, bus.instr, tag(32'h100));
    end
    next_cycle();
    bus.instr_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sample();
      n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h100 + 32'(k * 4)) begin
        n_bad++; $display("FAIL redir_drain: got v=%b pc=%h expected %h", bus.instr_valid, bus.instr_pc, 32'h100 + 32'(k * 4));
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_pop();
    logic [31:0] exp_pc;
    logic        done;
    int          npop;
    exp_pc = 32'h0; done = 1'b0; npop = 0;
    do_reset(1'b1);
    for (int c = 0; c < 20; c++) begin
      bus.redirect = 1'b0;
      if (!done && bus.instr_valid && bus.instr_pc == 32'h8) begin
        bus.redirect = 1'b1;
        bus.redirect_pc = 32'h200;
      end
      sample();
      if (bus.instr_valid) begin
        n_cmp++; if (bus.instr_pc !== exp_pc || bus.instr !== tag(exp_pc)) begin
          n_bad++; $display("FAIL rpop_seq: got pc=%h instr=%h expected pc=%h", bus.instr_pc, bus.instr, exp_pc);
        end
        npop++;
        exp_pc = exp_pc + 32'h4;
      end
      if (bus.redirect) begin
        done = 1'b1;
        exp_pc = 32'h200;
      end
      next_cycle();
    end
    bus.redirect = 1'b0;
    n_cmp++; if (!done || npop < 8) begin n_bad++; $display("FAIL rpop_progress: got redirected=%b pops=%0d expected 1 and >=8", done, npop); end
  endtask

  task automatic test_wrap();
    logic [31:0] exp_req [3];
    logic [31:0] exp_pop [3];
    int nreq;
    int npop;
    exp_req[0] = 32'hFFFF_FFFC; exp_req[1] = 32'h0; exp_req[2] = 32'h4;
    nreq = 0; npop = 0;
    for (int k = 0; k < 3; k++) exp_pop[k] = exp_req[k];
    do_reset(1'b1);
    bus.redirect = 1'b1;                        // during the idle start cycle
    bus.redirect_pc = 32'hFFFF_FFFE;
    sample();
    next_cycle();
    bus.redirect = 1'b0;
    sample();
    n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hFFFF_FFFC) begin
      n_bad++; $display("FAIL wrap_first_req: got req=%b addr=%h expected req=1 addr=fffffffc", bus.imem_req, bus.imem_addr);
    end
    for (int c = 0; c < 8; c++) begin
      if (bus.imem_req && nreq < 3) begin
        n_cmp++; if (bus.imem_addr !== exp_req[nreq]) begin
          n_bad++; $display("FAIL wrap_req: got %h expected %h", bus.imem_addr, exp_req[nreq]);
        end
        nreq++;
      end
      if (bus.instr_valid && npop < 3) begin
        n_cmp++; if (bus.instr_pc !== exp_pop[npop] || bus.instr !== tag(exp_pop[npop])) begin
          n_bad++; $display("FAIL wrap_pop: got pc=%h instr=%h expected pc=%h", bus.instr_pc, bus.instr, exp_pop[npop]);
        end
        npop++;
      end
      next_cycle();
      sample();
    end
    n_cmp++; if (nreq != 3 || npop != 3) begin n_bad++; $display("FAIL wrap_count: got req=%0d pop=%0d expected 3/3", nreq, npop); end
  endtask

  task automatic test_reset_mid();
    int npop;
    npop = 0;
    do_reset(1'b0);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h300;
    next_cycle();
    bus.redirect = 1'b0;
    repeat (10) next_cycle();
    sample();
    n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== 32'h300) begin
      n_bad++; $display("FAIL rmid_pre: got v=%b pc=%h expected v=1 pc=00000300", bus.instr_valid, bus.instr_pc);
    end
    next_cycle();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.instr_valid !== 1'b0 || bus.instr !== NOP || bus.instr_pc !== 32'h0) begin
      n_bad++; $display("FAIL rmid_async: got v=%b instr=%h pc=%h expected v=0 instr=%h pc=0", bus.instr_valid, bus.instr, bus.instr_pc, NOP);
    end
    n_cmp++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0) begin
      n_bad++; $display("FAIL rmid_req: got req=%b addr=%h expected req=0 addr=0", bus.imem_req, bus.imem_addr);
    end
    next_cycle();
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      sample();
      if (bus.instr_valid) begin
        n_cmp++; if (bus.instr_pc !== 32'(npop * 4) || bus.instr !== tag(32'(npop * 4))) begin
          n_bad++; $display("FAIL rmid_refetch: got pc=%h instr=%h expected pc=%h", bus.instr_pc, bus.instr, 32'(npop * 4));
        end
        npop++;
      end
      next_cycle();
    end
    n_cmp++; if (npop < 6) begin n_bad++; $display("FAIL rmid_progress: got %0d pops expected >=6", npop); end
  endtask

  // Reference model: the consumed stream and the fetch stream are both
  // "start address, then +4 each", restarted at a redirect; at most DEPTH
  // words may be requested but not yet consumed.
  task automatic test_random();
    logic [31:0] exp_fetch;
    logic [31:0] exp_head;
    int          outstanding;
    int          npop;
    logic        prev_stall;
    logic [31:0] prev_pc;
    logic [31:0] prev_instr;
    exp_fetch = 32'h0; exp_head = 32'h0; outstanding = 0; npop = 0;
    prev_stall = 1'b0; prev_pc = '0; prev_instr = '0;
    do_reset(1'b1);
    for (int c = 0; c < 3000; c++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      bus.redirect    = ($urandom_range(0, 39) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                    : 32'($urandom());
      sample();
      n_cmp++; if (bus.imem_addr[1:0] !== 2'b00) begin n_bad++; $display("FAIL rnd_align: got %h", bus.imem_addr); end
      if (prev_stall) begin
        n_cmp++; if (bus.instr_valid !== 1'b1 || bus.instr_pc !== prev_pc || bus.instr !== prev_instr) begin
          n_bad++; $display("FAIL rnd_stable: got v=%b pc=%h instr=%h expected pc=%h instr=%h", bus.instr_valid, bus.instr_pc, bus.instr, prev_pc, prev_instr);
        end
      end
      if (!bus.instr_valid) begin
        n_cmp++; if (bus.instr !== NOP || bus.instr_pc !== 32'h0) begin
          n_bad++; $display("FAIL rnd_empty: got instr=%h pc=%h expected %h/0", bus.instr, bus.instr_pc, NOP);
        end
      end else if (bus.instr_ready) begin
        n_cmp++; if (bus.instr_pc !== exp_head || bus.instr !== tag(exp_head)) begin
          n_bad++; $display("FAIL rnd_pop: got pc=%h instr=%h expected pc=%h instr=%h", bus.instr_pc, bus.instr, exp_head, tag(exp_head));
        end
        exp_head = exp_head + 32'h4;
        outstanding--;
        npop++;
      end
      if (bus.redirect) begin
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL rnd_redir_req: got %b expected 0", bus.imem_req); end
        exp_fetch   = bus.redirect_pc & ~32'h3;
        exp_head    = exp_fetch;
        outstanding = 0;
      end else if (bus.imem_req) begin
        n_cmp++; if (bus.imem_addr !== exp_fetch) begin
          n_bad++; $display("FAIL rnd_fetch: got %h expected %h", bus.imem_addr, exp_fetch);
        end
        exp_fetch = exp_fetch + 32'h4;
        outstanding++;
        n_cmp++; if (outstanding > DEPTH) begin
          n_bad++; $display("FAIL rnd_credit: got %0d outstanding expected <=%0d", outstanding, DEPTH);
        end
      end
      prev_stall = bus.instr_valid & ~bus.instr_ready & ~bus.redirect;
      prev_pc    = bus.instr_pc;
      prev_instr = bus.instr;
      next_cycle();
    end
    bus.redirect = 1'b0;
    n_cmp++; if (npop < 500) begin n_bad++; $display("FAIL rnd_progress: got %0d pops expected >=500", npop); end
  endtask

  initial begin
    bus.instr_ready = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
